// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, constants and round helper functions.
package sha256_pkg;

    typedef enum logic [1:0] {StIdle, StComp, StAdd} state_e;

    // Field a lands in the top 32 bits, so a packed work_t doubles as H0..H7 / digest layout.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } work_t;

    localparam work_t IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic work_t add_work(input work_t x, input work_t y);
        work_t s;
        s.a = x.a + y.a;
        s.b = x.b + y.b;
        s.c = x.c + y.c;
        s.d = x.d + y.d;
        s.e = x.e + y.e;
        s.f = x.f + y.f;
        s.g = x.g + y.g;
        s.h = x.h + y.h;
        return s;
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round.
module sha256_round
    import sha256_pkg::*;
(
    input  work_t       st_i,
    input  logic [31:0] w_i,
    input  logic [31:0] k_i,
    output work_t       st_o
);

    logic [31:0] t1;
    logic [31:0] t2;

    always_comb begin
        t1   = st_i.h + big_sigma1(st_i.e) + ch(st_i.e, st_i.f, st_i.g) + k_i + w_i;
        t2   = big_sigma0(st_i.a) + maj(st_i.a, st_i.b, st_i.c);
        st_o = '{a: t1 + t2, b: st_i.a, c: st_i.b, d: st_i.c,
                 e: st_i.d + t1, f: st_i.e, g: st_i.f, h: st_i.g};
    end

endmodule

// File: rtl/sha256_multiblock_core.sv
// Multi-block SHA-256 engine, ROUNDS_PER_CYCLE rounds per clock, chaining H across blocks.
// Define SHA256_MIDSTATE_EN to add a loadable midstate used in place of IV on blk_first.
module sha256_multiblock_core
    import sha256_pkg::*;
#(
    parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
`ifdef SHA256_MIDSTATE_EN
    input  logic         mid_load,
    input  logic [255:0] mid_data,
`endif
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    input  logic         blk_last,
    output logic         digest_valid,
    output logic [255:0] digest,
    output logic         busy
);

    localparam int unsigned R         = ROUNDS_PER_CYCLE;
    localparam logic [5:0]  LAST_STEP = 6'(64 / R - 1);

    if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rounds
        $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] w_q [16];
    logic [31:0] w_d [16];
    work_t       work_q, work_d;
    work_t       h_q, h_d;
    work_t       chain_q, chain_d;
    work_t       digest_q, digest_d;
    logic        last_q, last_d;
    logic        dv_q, dv_d;

    work_t       init_src;
    work_t       src;
    work_t       rnd [R + 1];
    logic [31:0] ext [16 + R];

`ifdef SHA256_MIDSTATE_EN
    work_t mid_q, mid_d;

    assign mid_d    = (state_q == StIdle && mid_load) ? work_t'(mid_data) : mid_q;
    assign init_src = mid_q;

    always_ff @(posedge clk) begin
        if (rst) mid_q <= IV;
        else     mid_q <= mid_d;
    end
`else
    assign init_src = IV;
`endif

    assign src = blk_first ? init_src : h_q;

    // ext[0..15] is the live window W[t..t+15]; ext[16..] are the words produced this edge.
    always_comb begin
        for (int i = 0; i < 16; i++) ext[i] = w_q[i];
        for (int j = 0; j < int'(R); j++) begin
            ext[16 + j] = small_sigma1(ext[14 + j]) + ext[9 + j]
                        + small_sigma0(ext[1 + j]) + ext[j];
        end
    end

    assign rnd[0] = work_q;

    for (genvar j = 0; j < int'(R); j++) begin : g_round
        logic [5:0] k_idx;
        assign k_idx = 6'(32'(cnt_q) * R + j);

        sha256_round u_round (
            .st_i (rnd[j]),
            .w_i  (ext[j]),
            .k_i  (K[k_idx]),
            .st_o (rnd[j + 1])
        );
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_d      = w_q;
        work_d   = work_q;
        h_d      = h_q;
        chain_d  = chain_q;
        last_d   = last_q;
        digest_d = digest_q;
        dv_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (blk_valid) begin
                    state_d = StComp;
                    cnt_d   = '0;
                    for (int i = 0; i < 16; i++) w_d[i] = blk_data[511 - 32 * i -: 32];
                    last_d  = blk_last;
                    chain_d = src;
                    work_d  = src;
                end
            end
            StComp: begin
                work_d = rnd[R];
                for (int i = 0; i < 16; i++) w_d[i] = ext[int'(R) + i];
                cnt_d  = cnt_q + 6'd1;
                if (cnt_q == LAST_STEP) state_d = StAdd;
            end
            StAdd: begin
                h_d = add_work(chain_q, work_q);
                if (last_q) begin
                    digest_d = h_d;
                    dv_d     = 1'b1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
            work_q   <= '0;
            h_q      <= IV;
            chain_q  <= '0;
            digest_q <= '0;
            last_q   <= 1'b0;
            dv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            w_q      <= w_d;
            work_q   <= work_d;
            h_q      <= h_d;
            chain_q  <= chain_d;
            digest_q <= digest_d;
            last_q   <= last_d;
            dv_q     <= dv_d;
        end
    end

    assign blk_ready    = (state_q == StIdle);
    assign busy         = (state_q != StIdle);
    assign digest_valid = dv_q;
    assign digest       = digest_q;

endmodule

// File: tb/tb_sha256_multiblock_core.sv
// Directed bench for sha256_multiblock_core: four instances with 1, 2, 4 and 8 rounds per clock.
module tb_sha256_multiblock_core;

    localparam int NI = 4;

    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_A     = {32'h61800000, 448'h0, 32'h00000008};
    localparam logic [511:0] BLK_TWO1  = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};

    localparam logic [255:0] D_ABC   =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_TWO   =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] D_A     =
        256'hca978112ca1bbdcafac231b39a23dc4da786eff8147c4e72b9807785afee48bb;
    localparam logic [255:0] H_MID1  =
        256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a;

    logic         clk;
    logic         rst;
    logic         blk_valid    [NI];
    logic         blk_ready    [NI];
    logic [511:0] blk_data     [NI];
    logic         blk_first    [NI];
    logic         blk_last     [NI];
    logic         digest_valid [NI];
    logic [255:0] digest       [NI];
    logic         busy         [NI];
`ifdef SHA256_MIDSTATE_EN
    logic         mid_load     [NI];
    logic [255:0] mid_data     [NI];
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pulses [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sha256_multiblock_core #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
            .clk          (clk),
            .rst          (rst),
`ifdef SHA256_MIDSTATE_EN
            .mid_load     (mid_load[g]),
            .mid_data     (mid_data[g]),
`endif
            .blk_valid    (blk_valid[g]),
            .blk_ready    (blk_ready[g]),
            .blk_data     (blk_data[g]),
            .blk_first    (blk_first[g]),
            .blk_last     (blk_last[g]),
            .digest_valid (digest_valid[g]),
            .digest       (digest[g]),
            .busy         (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NI; i++) if (digest_valid[i] === 1'b1) pulses[i] <= pulses[i] + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge after the accepting edge with acc = cyc there.
    task automatic send(input int idx, input logic [511:0] data, input logic first,
                        input logic last, output int acc);
        int n;
        n = 0;
        blk_data[idx]  = data;
        blk_first[idx] = first;
        blk_last[idx]  = last;
        blk_valid[idx] = 1'b1;
        while (blk_ready[idx] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (blk_ready[idx] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout inst %0d: blk_ready stayed %b, required 1", idx,
                     blk_ready[idx]);
            acc = -1;
        end else begin
            @(negedge clk);
            acc = cyc;
        end
        blk_valid[idx] = 1'b0;
        blk_data[idx]  = '0;
        blk_first[idx] = 1'b0;
        blk_last[idx]  = 1'b0;
    endtask

    task automatic wait_dv(input int idx, output int when);
        int n;
        n = 0;
        while (digest_valid[idx] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        when = (digest_valid[idx] === 1'b1) ? cyc : -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            checks += 4;
            if (blk_ready[i] !== 1'b1) begin
                errors++;
                $display("FAIL reset_ready inst %0d: got %b, required 1", i, blk_ready[i]);
            end
            if (busy[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_busy inst %0d: got %b, required 0", i, busy[i]);
            end
            if (digest_valid[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_dv inst %0d: got %b, required 0", i, digest_valid[i]);
            end
            if (digest[i] !== 256'h0) begin
                errors++;
                $display("FAIL reset_digest inst %0d: got %h, required 0", i, digest[i]);
            end
        end
    endtask

    task automatic test_abc_r1();
        int acc, when, p0;
        p0 = pulses[0];
        send(0, BLK_ABC, 1'b1, 1'b1, acc);
        wait_dv(0, when);
        checks += 4;
        if (when - acc !== 65) begin
            errors++;
            $display("FAIL abc_latency: got %0d, required 65", when - acc);
        end
        if (digest[0] !== D_ABC) begin
            errors++;
            $display("FAIL abc_digest: got %h, required %h", digest[0], D_ABC);
        end
        if (blk_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL abc_ready_with_dv: ready %b busy %b, required 1 0", blk_ready[0],
                     busy[0]);
        end
        @(negedge clk);
        if (digest_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL abc_dv_width: dv got %b one cycle later, required 0",
                     digest_valid[0]);
        end
        repeat (3) @(negedge clk);
        checks += 2;
        if (digest[0] !== D_ABC) begin
            errors++;
            $display("FAIL abc_digest_hold: got %h, required %h", digest[0], D_ABC);
        end
        if (pulses[0] - p0 !== 1) begin
            errors++;
            $display("FAIL abc_pulse_count: got %0d, required 1", pulses[0] - p0);
        end
    endtask

    task automatic test_empty_r4();
        int acc, when;
        send(2, BLK_EMPTY, 1'b1, 1'b1, acc);
        wait_dv(2, when);
        checks += 2;
        if (when - acc !== 17) begin
            errors++;
            $display("FAIL empty_latency: got %0d, required 17", when - acc);
        end
        if (digest[2] !== D_EMPTY) begin
            errors++;
            $display("FAIL empty_digest: got %h, required %h", digest[2], D_EMPTY);
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] prev [NI];
        int acc1, acc2, when, p0, steps;
        prev = '{D_ABC, 256'h0, D_EMPTY, 256'h0};
        for (int i = 0; i < NI; i++) begin
            steps = 64 >> i;
            p0    = pulses[i];
            send(i, BLK_TWO1, 1'b1, 1'b0, acc1);
            send(i, BLK_TWO2, 1'b0, 1'b1, acc2);
            checks += 3;
            if (acc2 - acc1 !== steps + 2) begin
                errors++;
                $display("FAIL b2b_accept_gap inst %0d: got %0d, required %0d", i, acc2 - acc1,
                         steps + 2);
            end
            if (pulses[i] !== p0) begin
                errors++;
                $display("FAIL b2b_no_mid_pulse inst %0d: pulses got %0d, required %0d", i,
                         pulses[i], p0);
            end
            if (digest[i] !== prev[i]) begin
                errors++;
                $display("FAIL b2b_digest_unchanged inst %0d: got %h, required %h", i,
                         digest[i], prev[i]);
            end
            wait_dv(i, when);
            @(negedge clk);
            checks += 3;
            if (when - acc2 !== steps + 1) begin
                errors++;
                $display("FAIL b2b_latency inst %0d: got %0d, required %0d", i, when - acc2,
                         steps + 1);
            end
            if (digest[i] !== D_TWO) begin
                errors++;
                $display("FAIL b2b_digest inst %0d: got %h, required %h", i, digest[i], D_TWO);
            end
            if (pulses[i] - p0 !== 1) begin
                errors++;
                $display("FAIL b2b_pulse_count inst %0d: got %0d, required 1", i,
                         pulses[i] - p0);
            end
        end
    endtask

    task automatic test_chain_reset();
        int acc, when;
        send(1, BLK_A, 1'b1, 1'b1, acc);
        wait_dv(1, when);
        checks += 2;
        if (when - acc !== 33) begin
            errors++;
            $display("FAIL a_latency: got %0d, required 33", when - acc);
        end
        if (digest[1] !== D_A) begin
            errors++;
            $display("FAIL a_digest: got %h, required %h", digest[1], D_A);
        end
        send(1, BLK_ABC, 1'b1, 1'b1, acc);
        wait_dv(1, when);
        checks++;
        if (digest[1] !== D_ABC) begin
            errors++;
            $display("FAIL chain_reset_digest: got %h, required %h", digest[1], D_ABC);
        end
    endtask

    task automatic test_reset_mid();
        int acc, when, p0;
        send(0, BLK_ABC, 1'b1, 1'b1, acc);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks += 4;
        if (blk_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready: got %b, required 1", blk_ready[0]);
        end
        if (busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy: got %b, required 0", busy[0]);
        end
        if (digest_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort_dv: got %b, required 0", digest_valid[0]);
        end
        if (digest[0] !== 256'h0) begin
            errors++;
            $display("FAIL abort_digest: got %h, required 0", digest[0]);
        end
        p0 = pulses[0];
        repeat (80) @(negedge clk);
        checks++;
        if (pulses[0] !== p0) begin
            errors++;
            $display("FAIL abort_no_pulse: pulses got %0d, required %0d", pulses[0], p0);
        end
        send(0, BLK_ABC, 1'b1, 1'b1, acc);
        wait_dv(0, when);
        checks++;
        if (digest[0] !== D_ABC) begin
            errors++;
            $display("FAIL abort_then_abc: got %h, required %h", digest[0], D_ABC);
        end
        // After reset H is IV, so a non-first block still hashes as a fresh message.
        send(2, BLK_ABC, 1'b0, 1'b1, acc);
        wait_dv(2, when);
        checks++;
        if (digest[2] !== D_ABC) begin
            errors++;
            $display("FAIL first0_after_reset: got %h, required %h", digest[2], D_ABC);
        end
    endtask

`ifdef SHA256_MIDSTATE_EN
    task automatic test_midstate();
        int acc, when;
        mid_load[1] = 1'b1;
        mid_data[1] = H_MID1;
        @(negedge clk);
        mid_load[1] = 1'b0;
        send(1, BLK_TWO2, 1'b1, 1'b1, acc);
        repeat (3) @(negedge clk);
        mid_load[1] = 1'b1;
        mid_data[1] = 256'h0;
        @(negedge clk);
        mid_load[1] = 1'b0;
        wait_dv(1, when);
        checks++;
        if (digest[1] !== D_TWO) begin
            errors++;
            $display("FAIL mid_digest: got %h, required %h", digest[1], D_TWO);
        end
        @(negedge clk);
        send(1, BLK_TWO2, 1'b1, 1'b1, acc);
        wait_dv(1, when);
        checks++;
        if (digest[1] !== D_TWO) begin
            errors++;
            $display("FAIL mid_load_in_comp_ignored: got %h, required %h", digest[1], D_TWO);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            blk_valid[i] = 1'b0;
            blk_data[i]  = '0;
            blk_first[i] = 1'b0;
            blk_last[i]  = 1'b0;
            pulses[i]    = 0;
`ifdef SHA256_MIDSTATE_EN
            mid_load[i]  = 1'b0;
            mid_data[i]  = '0;
`endif
        end
        @(negedge clk);
        test_reset();
        test_abc_r1();
        test_empty_r4();
        test_back_to_back();
        test_chain_reset();
        test_reset_mid();
`ifdef SHA256_MIDSTATE_EN
        test_midstate();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
